// File: rtl/proc_pkg.sv
// Shared constants and types for the proc_ctrl control unit.
// Field positions derive from REG_NUM so the IR layout stays consistent with the register count.
package proc_pkg;

  localparam int unsigned REG_NUM   = 4;
  localparam int unsigned REG_W     = $clog2(REG_NUM);
  localparam int unsigned DATAWIDTH = 2 + 2 * REG_W;

  localparam int unsigned OP_LSB = 2 * REG_W;
  localparam int unsigned X_LSB  = REG_W;
  localparam int unsigned Y_LSB  = 0;

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    T0,
    T1,
    T2,
    T3
  } tstep_e;

  typedef logic [REG_W-1:0] reg_idx_t;

endpackage

// File: rtl/proc_ctrl_if.sv
// Control-unit boundary: instruction input, run request, and datapath/busmux controls.
interface proc_ctrl_if;
  import proc_pkg::*;

  logic                 run;
  logic [DATAWIDTH-1:0] din;
  logic [REG_NUM-1:0]   rout;
  logic                 gout;
  logic                 dinout;
  logic [REG_NUM-1:0]   rin;
  logic                 ain;
  logic                 gin;
  logic                 addsub;
  logic                 done;
  logic                 busy;

  modport master (
    input  run, din,
    output rout, gout, dinout, rin, ain, gin, addsub, done, busy
  );

  modport slave (
    output run, din,
    input  rout, gout, dinout, rin, ain, gin, addsub, done, busy
  );

endinterface

// File: rtl/proc_regdec.sv
// Register index to reversed one-hot decoder: index r drives bit (N-1-r), gated by en.
module proc_regdec #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      onehot[N-1-i] = en && (idx == W'(i));
    end
  end

endmodule

// File: rtl/proc_ctrl.sv
// Multi-cycle control unit: fetches an instruction in T0 and sequences the datapath through
// T1..T3. All control outputs are decoded combinationally from the step register and IR.
module proc_ctrl
  import proc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  proc_ctrl_if.master  bus
);

  tstep_e               tstep_q, tstep_d;
  logic [DATAWIDTH-1:0] ir_q, ir_d;

  logic [1:0] op;
  reg_idx_t   rx, ry;
  reg_idx_t   src_idx;
  logic       src_en;
  logic       dst_en;

  assign op = ir_q[OP_LSB +: 2];
  assign rx = ir_q[X_LSB +: REG_W];
  assign ry = ir_q[Y_LSB +: REG_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tstep_q <= T0;
      ir_q    <= '0;
    end else begin
      tstep_q <= tstep_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    tstep_d    = tstep_q;
    ir_d       = ir_q;
    src_idx    = rx;
    src_en     = 1'b0;
    dst_en     = 1'b0;
    bus.gout   = 1'b0;
    bus.dinout = 1'b0;
    bus.ain    = 1'b0;
    bus.gin    = 1'b0;
    bus.addsub = 1'b0;
    bus.done   = 1'b0;
    bus.busy   = 1'b0;

    case (tstep_q)
      T0: begin
        // Run is only honoured here, so requests while busy never queue.
        if (bus.run) begin
          ir_d    = bus.din;
          tstep_d = T1;
        end
      end
      T1: begin
        bus.busy = 1'b1;
        case (op)
          OP_MV: begin
            src_idx  = ry;
            src_en   = 1'b1;
            dst_en   = 1'b1;
            bus.done = 1'b1;
            tstep_d  = T0;
          end
          OP_MVI: begin
            bus.dinout = 1'b1;
            dst_en     = 1'b1;
            bus.done   = 1'b1;
            tstep_d    = T0;
          end
          OP_ADD, OP_SUB: begin
            src_idx = rx;
            src_en  = 1'b1;
            bus.ain = 1'b1;
            tstep_d = T2;
          end
        endcase
      end
      T2: begin
        bus.busy   = 1'b1;
        src_idx    = ry;
        src_en     = 1'b1;
        bus.gin    = 1'b1;
        bus.addsub = ir_q[OP_LSB];
        tstep_d    = T3;
      end
      T3: begin
        bus.busy = 1'b1;
        bus.gout = 1'b1;
        dst_en   = 1'b1;
        bus.done = 1'b1;
        tstep_d  = T0;
      end
      default: tstep_d = T0;
    endcase
  end

  proc_regdec #(
    .N(REG_NUM),
    .W(REG_W)
  ) u_src_dec (
    .idx   (src_idx),
    .en    (src_en),
    .onehot(bus.rout)
  );

  proc_regdec #(
    .N(REG_NUM),
    .W(REG_W)
  ) u_dst_dec (
    .idx   (rx),
    .en    (dst_en),
    .onehot(bus.rin)
  );

endmodule

// File: tb/tb_proc_ctrl.sv
// Bench for proc_ctrl: a small register-file datapath driven by the DUT controls, checked
// cycle by cycle against an instruction-level reference model and arithmetic results.
module tb_proc_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  proc_ctrl_if bus ();

  proc_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Bench datapath: R0..R3, A, G.
  logic [5:0] r[4];
  logic [5:0] snap[4];
  logic [5:0] pre[4];
  logic [5:0] a_reg, g_reg;

  // Reference model: cycle index within the current instruction (0 = idle) and its word.
  int         phase;
  logic [5:0] mir;

  function automatic logic [3:0] oh(input logic [1:0] i);
    logic [3:0] v;
    v = 4'b1000;
    return v >> i;
  endfunction

  // Packing: rout[14:11] gout[10] dinout[9] rin[8:5] ain[4] gin[3] addsub[2] done[1] busy[0]
  function automatic logic [14:0] expect_out(input logic [5:0] ir, input int ph);
    logic [1:0] op, x, y;
    logic [3:0] ro, ri;
    logic       go, dio, ai, gi, asb, dn, bz;
    op = ir[5:4];
    x  = ir[3:2];
    y  = ir[1:0];
    ro = '0; ri = '0;
    go = 0; dio = 0; ai = 0; gi = 0; asb = 0; dn = 0; bz = 0;
    case (ph)
      1: begin
        bz = 1'b1;
        if (op == 2'd0) begin
          ro = oh(y); ri = oh(x); dn = 1'b1;
        end else if (op == 2'd1) begin
          dio = 1'b1; ri = oh(x); dn = 1'b1;
        end else begin
          ro = oh(x); ai = 1'b1;
        end
      end
      2: begin
        bz = 1'b1; ro = oh(y); gi = 1'b1; asb = (op == 2'd3);
      end
      3: begin
        bz = 1'b1; go = 1'b1; ri = oh(x); dn = 1'b1;
      end
      default: ;
    endcase
    return {ro, go, dio, ri, ai, gi, asb, dn, bz};
  endfunction

  function automatic logic [14:0] obs_vec();
    return {bus.rout, bus.gout, bus.dinout, bus.rin, bus.ain, bus.gin, bus.addsub,
            bus.done, bus.busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic cycle(input logic run, input logic [5:0] d);
    logic [5:0]  busv, want;
    logic [14:0] e;
    logic [1:0]  op, x, y;
    bus.run = run;
    bus.din = d;
    #1;
    e = expect_out(mir, phase);
    check("outputs", 32'(obs_vec()), 32'(e));
    check("one_bus_source", 32'($countones({bus.rout, bus.gout, bus.dinout}) <= 1), 32'd1);

    busv = d;
    if (bus.gout) busv = g_reg;
    for (int i = 0; i < 4; i++) if (bus.rout[3-i]) busv = r[i];
    if (bus.gin) g_reg = bus.addsub ? a_reg - busv : a_reg + busv;
    if (bus.ain) a_reg = busv;
    for (int i = 0; i < 4; i++) if (bus.rin[3-i]) r[i] = busv;

    if (phase == 0) begin
      if (run) begin
        mir   = d;
        phase = 1;
        snap  = r;
      end
    end else if (e[1]) begin
      op = mir[5:4]; x = mir[3:2]; y = mir[1:0];
      case (op)
        2'd0:    want = snap[y];
        2'd1:    want = d;
        2'd2:    want = snap[x] + snap[y];
        default: want = snap[x] - snap[y];
      endcase
      check("result", 32'(r[x]), 32'(want));
      phase = 0;
    end else begin
      phase++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] x, input logic [1:0] y,
                       input logic [5:0] imm, input logic busy_run);
    int n;
    n = 0;
    cycle(1'b1, {op, x, y});
    while (phase != 0 && n < 8) begin
      cycle(busy_run, (phase == 1 && op == 2'd1) ? imm : 6'($urandom));
      n++;
    end
    check("instr_retired", 32'(phase), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 6'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    bus.run = 1'b0;
    bus.din = '0;
    for (int i = 0; i < 4; i++) r[i] = '0;
    a_reg = '0;
    g_reg = '0;
    phase = 0;
    mir   = '0;
    #1;
    check("reset_outputs", 32'(obs_vec()), 32'd0);
    @(posedge clk);
    #1;
    check("reset_held_outputs", 32'(obs_vec()), 32'd0);
    rst = 1'b0;
    idle(2);

    // mvi R2,#5 ; mv R0,R2
    issue(2'd1, 2'd2, 2'd0, 6'd5, 1'b0);
    check("mvi_r2", 32'(r[2]), 32'd5);
    issue(2'd0, 2'd0, 2'd2, 6'd0, 1'b0);
    check("mv_r0", 32'(r[0]), 32'd5);

    // add R1,R2 with R1=3, R2=5
    issue(2'd1, 2'd1, 2'd0, 6'd3, 1'b0);
    issue(2'd2, 2'd1, 2'd2, 6'd0, 1'b0);
    check("add_r1", 32'(r[1]), 32'd8);

    // sub R3,R0 with R3=2, R0=5 wraps to 61
    issue(2'd1, 2'd3, 2'd0, 6'd2, 1'b0);
    issue(2'd3, 2'd3, 2'd0, 6'd0, 1'b0);
    check("sub_r3_wrap", 32'(r[3]), 32'h3d);

    // Run held high across mv then add: add is fetched right after mv's Done
    issue(2'd0, 2'd2, 2'd2, 6'd0, 1'b1);
    issue(2'd2, 2'd0, 2'd1, 6'd0, 1'b1);
    check("b2b_add_r0", 32'(r[0]), 32'd13);
    idle(1);

    // Run pulse in T2 is ignored
    cycle(1'b1, {2'd3, 2'd1, 2'd2});
    cycle(1'b0, 6'($urandom));
    cycle(1'b1, 6'b010000);
    cycle(1'b0, 6'($urandom));
    idle(1);
    check("run_pulse_t2_ignored", 32'(phase), 32'd0);

    // Reset mid-add while in T2
    pre = r;
    cycle(1'b1, {2'd2, 2'd1, 2'd3});
    cycle(1'b0, 6'($urandom));
    rst = 1'b1;
    #1;
    check("rst_mid_add_async", 32'(obs_vec()), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_add_held", 32'(obs_vec()), 32'd0);
    rst   = 1'b0;
    phase = 0;
    mir   = '0;
    idle(2);
    for (int i = 0; i < 4; i++) check("rst_no_writeback", 32'(r[i]), 32'(pre[i]));

    // Randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      issue(2'($urandom), 2'($urandom), 2'($urandom), 6'($urandom), 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Control unit for the 4-register, 6-bit datapath; sits directly upstream of busmux.
- Captures a 6-bit instruction from DIN when Run is high.
- Sequences the datapath through T0..T3, driving busmux selects (Rout/Gout/DINout) and register/ALU enables (Rin/Ain/Gin/AddSub).
- Pulses Done when the instruction retires.

Parameters:
- REG_NUM, 4, number of general registers; register-field width is clog2(REG_NUM) = 2.
- DATAWIDTH, 6, width of DIN and IR; must equal 2 + 2*clog2(REG_NUM).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Run  input  1  start request; sampled only in T0.
- DIN  input  DATAWIDTH  instruction word in T0; immediate operand in T1 of mvi (consumed via DINout).
- Rout  output  REG_NUM  one-hot bus-source select to busmux; MSB = R0, LSB = R3.
- Gout  output  1  drive G onto bus.
- DINout  output  1  drive DIN onto bus.
- Rin  output  REG_NUM  one-hot register write enable; MSB = R0, LSB = R3.
- Ain  output  1  load A from bus.
- Gin  output  1  load G with ALU result.
- AddSub  output  1  0 = add, 1 = subtract (A - bus).
- Done  output  1  one-cycle pulse on the final cycle of an instruction.
- Busy  output  1  high in T1..T3.

Behaviour:
- IR format: IR[5:4] opcode, IR[3:2] X, IR[1:0] Y.
- Opcodes: 00 mv Rx,Ry; 01 mvi Rx,#D; 10 add Rx,Ry; 11 sub Rx,Ry.
- Register index r maps to one-hot bit (REG_NUM-1-r): R0 -> 4'b1000, R3 -> 4'b0001. This matches busmux Sel decoding.
- State register Tstep in {T0,T1,T2,T3}. All outputs are combinational from Tstep and IR; no output registers.
- T0:
  - All outputs 0.
  - If Run=1: IR <= DIN, go to T1. Else stay in T0; IR holds.
- T1:
  - mv: Rout=onehot(Y), Rin=onehot(X), Done=1, go to T0.
  - mvi: DINout=1, Rin=onehot(X), Done=1, go to T0.
  - add/sub: Rout=onehot(X), Ain=1, go to T2.
- T2 (add/sub only): Rout=onehot(Y), Gin=1, AddSub=IR[4], go to T3.
- T3: Gout=1, Rin=onehot(X), Done=1, go to T0.
- Latency from the Run cycle to Done: mv/mvi 1 cycle (2 cycles total); add/sub 3 cycles (4 cycles total).
- Back-to-back: Run high in the cycle after Done starts the next instruction. Run high in T1..T3 is ignored and does not queue.
- mv Rx,Rx (X == Y) is legal: Rout and Rin assert the same bit.
- At most one of Rout bits, Gout, DINout is high in any cycle. All-zero means busmux defaults to DIN, which is harmless because no Rin/Ain is active.
- Reset (any time, including mid-instruction): Tstep <= T0 and IR <= 0 immediately. All outputs are 0 while Reset is high and on the first cycle after release. A partially executed add leaves A/G stale; no write-back occurs.
- No X propagation: a default branch sends Tstep to T0.

Decomposition:
- Package proc_pkg holds:
  - opcode constants OP_MV=2'b00, OP_MVI=2'b01, OP_ADD=2'b10, OP_SUB=2'b11;
  - state enum T0..T3 (2-bit);
  - field position constants.
- One sub-module, proc_regdec: index -> reversed one-hot decoder with an enable input. It is instantiated twice (source X/Y select and destination X).

Test Plan:
- Reset mid-add: issue add, assert Reset in T2 -> next edge Tstep=T0, all outputs 0, no Rin/Gout pulse, Done stays 0.
- mvi R2,#5: Run=1 with DIN=6'b01_10_00, then DIN=6'b000101 -> T1 shows DINout=1, Rin=4'b0010, Done=1; bench datapath R2=5.
- mv R0,R2: DIN=6'b00_00_10 -> T1 shows Rout=4'b0010, Rin=4'b1000, Done=1 exactly one cycle.
- add R1,R2 with R1=3, R2=5:
  - T1: Rout=0100, Ain.
  - T2: Rout=0010, Gin, AddSub=0.
  - T3: Gout, Rin=0100, Done.
  - Result: R1=8.
- sub R3,R0 with R3=2, R0=5 -> AddSub=1 in T2; R3=6'b111101 (wraps modulo 2^6).
- Back-to-back and ignored Run:
  - Run held high continuously across mv then add -> add is fetched the cycle after mv's Done.
  - Run pulses during T2 -> no effect.
  - In every cycle of this test, at most one bus source is active.
